// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pong_pkg
// Brief   : Shared types and constants for the VGA ball/bar pong demo.
// Revision: 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Game phase encoding, also exported on the debug/HEX state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    MISS      = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Playfield bounds in pixels (up/down/left/right).
  localparam int BOUND_U = 20;
  localparam int BOUND_D = 460;
  localparam int BOUND_L = 20;
  localparam int BOUND_R = 620;

  // Ball speed in pixels per frame.
  localparam int BALL_SPEED = 9;

  // Convert a decimal value 0..9999 to four packed BCD digits.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_bcd_inc4.sv
`default_nettype none
// ============================================================================
// Module  : bcd_inc4
// Brief   : Four-digit BCD incrementer with saturation at 9999.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_inc4 (
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        sat
);

  assign sat = (din == 16'h9999);

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and carries.
  always_comb begin
    logic carry;
    dout  = din;
    carry = en && !sat;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (din[i*4 +: 4] == 4'd9) begin
          dout[i*4 +: 4] = 4'd0;
        end else begin
          dout[i*4 +: 4] = din[i*4 +: 4] + 4'd1;
          carry          = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl
// Brief   : Game sequencing for the pong demo: frame strobe from VGA vsync,
//           frame-rate debounced serve key, serve/play/miss/game-over phases,
//           BCD score and lives counter.
// Revision: 1.0 - initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int MISS_Y       = 460,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SCORE_MAX    = 9999
) (
  input  logic        clk_25M,
  input  logic        reset,
  input  logic        vs,
  input  logic        key_serve_n,
  input  logic        bar_hit,
  input  logic [15:0] ball_bot_y,
  output logic        frame_stb,
  output logic        run,
  output logic        serve_hold,
  output logic        lose,
  output logic [15:0] score_bcd,
  output logic [1:0]  lives,
  output logic [2:0]  state_o
);

  localparam logic [15:0]        SCORE_MAX_BCD = to_bcd(SCORE_MAX);
  localparam logic [1:0]         LIVES_INIT    = 2'(LIVES);
  localparam logic [7:0]         SERVE_LAST    = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         MISS_LAST     = 8'(MISS_FRAMES - 1);
  localparam logic signed [15:0] MISS_Y_S      = 16'(MISS_Y);

  logic        vs_q;
  logic        key_s1, key_s2;
  logic        k1, k0;
  logic        hit_flag;
  logic        press;
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] score_n, score_inc;
  logic [1:0]  lives_n;
  logic        run_n, serve_hold_n, lose_n;
  logic        score_sat;
  logic        at_max;

  // Frame strobe: one cycle high, one cycle after vs falls.
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      vs_q      <= 1'b1;
      frame_stb <= 1'b0;
    end else begin
      vs_q      <= vs;
      frame_stb <= vs_q & ~vs;
    end
  end

  // Synchronize the serve key, then sample it once per frame for debounce.
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      k1     <= 1'b1;
      k0     <= 1'b1;
    end else begin
      key_s1 <= key_serve_n;
      key_s2 <= key_s1;
      if (frame_stb) begin
        k1 <= k0;
        k0 <= key_s2;
      end
    end
  end

  // One event per high-to-low transition seen at frame rate.
  assign press = frame_stb & k1 & ~k0;

  // Latch bar hits between strobes; a hit on the strobe cycle rolls into the next frame.
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      hit_flag <= 1'b0;
    end else if (frame_stb) begin
      hit_flag <= bar_hit;
    end else if (bar_hit) begin
      hit_flag <= 1'b1;
    end
  end

  bcd_inc4 u_bcd_inc4 (
    .en   (hit_flag),
    .din  (score_bcd),
    .dout (score_inc),
    .sat  (score_sat)
  );

  assign at_max = score_sat || (score_bcd == SCORE_MAX_BCD);

  // Game FSM state, counters and registered outputs.
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      score_bcd  <= 16'h0000;
      lives      <= LIVES_INIT;
      run        <= 1'b0;
      serve_hold <= 1'b1;
      lose       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      score_bcd  <= score_n;
      lives      <= lives_n;
      run        <= run_n;
      serve_hold <= serve_hold_n;
      lose       <= lose_n;
    end
  end

  // Next-state, counter and output decode; everything advances only on frame strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    score_n = score_bcd;
    lives_n = lives;
    if (frame_stb) begin
      case (state)
        IDLE, GAME_OVER: begin
          if (press) begin
            state_n = SERVE;
            cnt_n   = 8'd0;
            score_n = 16'h0000;
            lives_n = LIVES_INIT;
          end
        end
        SERVE: begin
          if (cnt == SERVE_LAST) begin
            state_n = PLAY;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        PLAY: begin
          // A hit in the same frame as a bottom crossing wins over the miss.
          if (hit_flag) begin
            if (!at_max) score_n = score_inc;
          end else if ($signed(ball_bot_y) >= MISS_Y_S) begin
            if (lives != 2'd0) lives_n = lives - 2'd1;
            state_n = MISS;
            cnt_n   = 8'd0;
          end
        end
        MISS: begin
          if (cnt == MISS_LAST) begin
            cnt_n   = 8'd0;
            state_n = (lives == 2'd0) ? GAME_OVER : SERVE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    run_n        = (state_n == PLAY);
    serve_hold_n = (state_n == IDLE) || (state_n == SERVE) || (state_n == GAME_OVER);
    lose_n       = (state_n == GAME_OVER);
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pong_game_ctrl
// Brief   : Scoreboard bench for pong_game_ctrl with short synthetic frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic        clk_25M = 1'b0;
  logic        reset   = 1'b1;
  logic        vs      = 1'b1;
  logic        key_serve_n = 1'b1;
  logic        bar_hit = 1'b0;
  logic [15:0] ball_bot_y = 16'd100;
  logic        frame_stb, run, serve_hold, lose;
  logic [15:0] score_bcd;
  logic [1:0]  lives;
  logic [2:0]  state_o;
  logic        frame_stb2, run2, serve_hold2, lose2;
  logic [15:0] score_bcd2;
  logic [1:0]  lives2;
  logic [2:0]  state_o2;
  logic        b_en, b_sat;
  logic [15:0] b_din, b_dout;

  int checks   = 0;
  int failures = 0;
  int fnum     = 0;
  int mf       = 0;
  int stb_cnt  = 0;
  bit done     = 0;

  typedef struct {
    int          f;
    logic [2:0]  st;
    logic        run;
    logic        sh;
    logic        lose;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [15:0] score2;
  } exp_t;
  exp_t exp_q[$];

  pong_game_ctrl dut (
    .clk_25M(clk_25M), .reset(reset), .vs(vs), .key_serve_n(key_serve_n),
    .bar_hit(bar_hit), .ball_bot_y(ball_bot_y), .frame_stb(frame_stb), .run(run),
    .serve_hold(serve_hold), .lose(lose), .score_bcd(score_bcd), .lives(lives),
    .state_o(state_o)
  );

  // Second instance with a low score ceiling to exercise saturation.
  pong_game_ctrl #(.SCORE_MAX(12)) dut_sat (
    .clk_25M(clk_25M), .reset(reset), .vs(vs), .key_serve_n(key_serve_n),
    .bar_hit(bar_hit), .ball_bot_y(ball_bot_y), .frame_stb(frame_stb2), .run(run2),
    .serve_hold(serve_hold2), .lose(lose2), .score_bcd(score_bcd2), .lives(lives2),
    .state_o(state_o2)
  );

  bcd_inc4 u_bcd (.en(b_en), .din(b_din), .dout(b_dout), .sat(b_sat));

  always #20 clk_25M = ~clk_25M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic push(input int f, input logic [2:0] st, input logic r, input logic sh,
                      input logic lo, input logic [15:0] sc, input logic [1:0] lv,
                      input logic [15:0] sc2);
    exp_t e;
    e = '{f: f, st: st, run: r, sh: sh, lose: lo, score: sc, lives: lv, score2: sc2};
    exp_q.push_back(e);
  endtask

  // One synthetic frame: optional bar hit mid-frame, then a 2-cycle vs low pulse.
  task automatic frame(input logic hit, input logic [15:0] by);
    ball_bot_y = by;
    repeat (2) @(negedge clk_25M);
    if (hit) bar_hit = 1'b1;
    @(negedge clk_25M);
    bar_hit = 1'b0;
    repeat (2) @(negedge clk_25M);
    vs = 1'b0;
    fnum++;
    repeat (2) @(negedge clk_25M);
    vs = 1'b1;
  endtask

  task automatic frames(input int n, input logic hit, input logic [15:0] by);
    for (int i = 0; i < n; i++) frame(hit, by);
  endtask

  // Monitor: after each strobe, compare the settled outputs against any expectation for that frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_25M);
      if (frame_stb && !reset) begin
        mf++;
        stb_cnt++;
        @(negedge clk_25M);
        chk($sformatf("f%0d stb_width", mf), 32'(frame_stb), 32'd0);
        while (exp_q.size() > 0 && exp_q[0].f <= mf) begin
          e = exp_q.pop_front();
          chk($sformatf("f%0d state", e.f), 32'(state_o), 32'(e.st));
          chk($sformatf("f%0d run", e.f), 32'(run), 32'(e.run));
          chk($sformatf("f%0d serve_hold", e.f), 32'(serve_hold), 32'(e.sh));
          chk($sformatf("f%0d lose", e.f), 32'(lose), 32'(e.lose));
          chk($sformatf("f%0d score", e.f), 32'(score_bcd), 32'(e.score));
          chk($sformatf("f%0d lives", e.f), 32'(lives), 32'(e.lives));
          chk($sformatf("f%0d score_sat", e.f), 32'(score_bcd2), 32'(e.score2));
        end
      end
    end
  end

  // Watchdog: the stimulus never waits on the DUT, but bound the run anyway.
  initial begin
    #(40 * 60000);
    if (!done) begin
      $display("FAIL watchdog actual=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    // Incrementer unit vectors.
    b_en = 1'b1; b_din = 16'h0999; #1;
    chk("bcd 0999+1", 32'(b_dout), 32'h1000);
    b_din = 16'h9999; #1;
    chk("bcd 9999 hold", 32'(b_dout), 32'h9999);
    chk("bcd 9999 sat", 32'(b_sat), 32'd1);
    b_din = 16'h0009; #1;
    chk("bcd 0009+1", 32'(b_dout), 32'h0010);
    b_en = 1'b0; b_din = 16'h1234; #1;
    chk("bcd disabled", 32'(b_dout), 32'h1234);

    repeat (3) @(negedge clk_25M);
    reset = 1'b0;
    chk("reset state", 32'(state_o), 32'(IDLE));
    chk("reset serve_hold", 32'(serve_hold), 32'd1);
    chk("reset lives", 32'(lives), 32'd3);

    // Idle frames with no key.
    push(1, IDLE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    push(3, IDLE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    frames(3, 0, 16'd100);
    @(negedge clk_25M);
    chk("stb count after 3 vs", 32'(stb_cnt), 32'd3);

    // Key held low from frame 4 to 70: one press at frame 5, serve 60 frames.
    key_serve_n = 1'b0;
    push(4,  IDLE,  0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    push(5,  SERVE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    push(64, SERVE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    push(65, PLAY,  1, 0, 0, 16'h0000, 2'd3, 16'h0000);
    push(66, PLAY,  1, 0, 0, 16'h0001, 2'd3, 16'h0001);
    push(77, PLAY,  1, 0, 0, 16'h0012, 2'd3, 16'h0012);
    push(78, PLAY,  1, 0, 0, 16'h0012, 2'd3, 16'h0012);
    push(79, PLAY,  1, 0, 0, 16'h0013, 2'd3, 16'h0012);
    push(80, MISS,  0, 0, 0, 16'h0013, 2'd2, 16'h0012);
    push(169, MISS, 0, 0, 0, 16'h0013, 2'd2, 16'h0012);
    push(170, SERVE, 0, 1, 0, 16'h0013, 2'd2, 16'h0012);
    push(229, SERVE, 0, 1, 0, 16'h0013, 2'd2, 16'h0012);
    push(230, PLAY, 1, 0, 0, 16'h0013, 2'd2, 16'h0012);
    push(231, PLAY, 1, 0, 0, 16'h0013, 2'd2, 16'h0012);
    push(232, MISS, 0, 0, 0, 16'h0013, 2'd1, 16'h0012);
    push(322, SERVE, 0, 1, 0, 16'h0013, 2'd1, 16'h0012);
    push(382, PLAY, 1, 0, 0, 16'h0013, 2'd1, 16'h0012);
    push(383, MISS, 0, 0, 0, 16'h0013, 2'd0, 16'h0012);
    push(473, GAME_OVER, 0, 1, 1, 16'h0013, 2'd0, 16'h0012);
    push(474, GAME_OVER, 0, 1, 1, 16'h0013, 2'd0, 16'h0012);
    push(475, SERVE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);
    push(535, PLAY, 1, 0, 0, 16'h0000, 2'd3, 16'h0000);
    push(536, PLAY, 1, 0, 0, 16'h0001, 2'd3, 16'h0001);
    push(537, IDLE, 0, 1, 0, 16'h0000, 2'd3, 16'h0000);

    frames(62, 0, 16'd100);             // frames 4..65
    frames(5, 1, 16'd100);              // frames 66..70, hits
    key_serve_n = 1'b1;
    frames(7, 1, 16'd100);              // frames 71..77, hits
    frame(0, 16'd459);                  // 78: just above miss line
    frame(1, 16'd460);                  // 79: hit beats miss
    frame(0, 16'd460);                  // 80: miss
    frames(90, 0, 16'd460);             // 81..170
    frames(60, 0, 16'd100);             // 171..230
    frame(0, 16'hFFFB);                 // 231: negative Y, no miss
    frame(0, 16'd500);                  // 232: miss
    frames(90, 0, 16'd500);             // 233..322
    frames(60, 0, 16'd100);             // 323..382
    frame(0, 16'd460);                  // 383: last miss
    frames(90, 0, 16'd460);             // 384..473
    key_serve_n = 1'b0;
    frames(3, 0, 16'd100);              // 474..476, press seen at 475
    key_serve_n = 1'b1;
    frames(59, 0, 16'd100);             // 477..535
    frame(1, 16'd100);                  // 536: hit

    // Mid-play reset between strobes.
    repeat (2) @(negedge clk_25M);
    reset = 1'b1;
    @(negedge clk_25M);
    reset = 1'b0;
    chk("midreset state", 32'(state_o), 32'(IDLE));
    chk("midreset run", 32'(run), 32'd0);
    chk("midreset serve_hold", 32'(serve_hold), 32'd1);
    chk("midreset lose", 32'(lose), 32'd0);
    chk("midreset score", 32'(score_bcd), 32'h0000);
    chk("midreset lives", 32'(lives), 32'd3);
    chk("midreset frame_stb", 32'(frame_stb), 32'd0);

    frame(0, 16'd100);                  // 537: idle after reset
    repeat (4) @(negedge clk_25M);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
